// File: rtl/data_mem_arbiter.sv
// Two-port valid/ready arbiter that sequences one-cycle accesses to the 128-byte, 24-bit-word data memory.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build gives port 0 fixed priority.
module data_mem_arbiter #(
  parameter int MEM_BYTES = 128,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 24
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              p0ReqValid_i,
  output logic              p0ReqReady_o,
  input  logic              p0Write_i,
  input  logic [ADDR_W-1:0] p0Addr_i,
  input  logic [DATA_W-1:0] p0WData_i,
  output logic              p0RspValid_o,
  output logic [DATA_W-1:0] p0RspData_o,
  output logic              p0RspErr_o,
  input  logic              p1ReqValid_i,
  output logic              p1ReqReady_o,
  input  logic              p1Write_i,
  input  logic [ADDR_W-1:0] p1Addr_i,
  input  logic [DATA_W-1:0] p1WData_i,
  output logic              p1RspValid_o,
  output logic [DATA_W-1:0] p1RspData_o,
  output logic              p1RspErr_o,
  output logic [ADDR_W-1:0] memAddress_o,
  output logic [DATA_W-1:0] memWriteData_o,
  output logic              memWrite_o,
  output logic              memRead_o,
  input  logic [DATA_W-1:0] memReadData_i
);

  localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(MEM_BYTES - 3);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                port_q, port_d;
  logic                p0RspValid_q, p0RspValid_d, p1RspValid_q, p1RspValid_d;
  logic [DATA_W-1:0]   p0RspData_q, p0RspData_d, p1RspData_q, p1RspData_d;
  logic                p0RspErr_q, p0RspErr_d, p1RspErr_q, p1RspErr_d;
  logic                p0Win, p1Win, p0Ready, p1Ready;
  logic                legal;
  logic [DATA_W-1:0]   rspData;

`ifdef ARB_ROUND_ROBIN_EN
  // rrLast_q remembers the last granted port; the other port wins a tie.
  logic rrLast_q, rrLast_d;

  always_comb begin
    p0Win = p0ReqValid_i & (~p1ReqValid_i | rrLast_q);
    p1Win = p1ReqValid_i & (~p0ReqValid_i | ~rrLast_q);
  end

  assign rrLast_d = (state_q == IDLE && (p0Win || p1Win)) ? p1Win : rrLast_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rrLast_q <= 1'b1;
    else         rrLast_q <= rrLast_d;
  end
`else
  always_comb begin
    p0Win = p0ReqValid_i;
    p1Win = p1ReqValid_i & ~p0ReqValid_i;
  end
`endif

  assign legal   = (addr_q <= LAST_WORD_ADDR);
  assign rspData = (legal && !write_q) ? memReadData_i : '0;

  always_comb begin
    state_d        = state_q;
    write_d        = write_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    port_d         = port_q;
    p0Ready        = 1'b0;
    p1Ready        = 1'b0;
    memAddress_o   = '0;
    memWriteData_o = '0;
    memWrite_o     = 1'b0;
    memRead_o      = 1'b0;
    case (state_q)
      IDLE: begin
        p0Ready = p0Win;
        p1Ready = p1Win;
        if (p0Win || p1Win) begin
          state_d = ACCESS;
          port_d  = p1Win;
          write_d = p1Win ? p1Write_i : p0Write_i;
          addr_d  = p1Win ? p1Addr_i  : p0Addr_i;
          wdata_d = p1Win ? p1WData_i : p0WData_i;
        end
      end
      ACCESS: begin
        state_d = IDLE;
        // An out-of-range word never reaches the memory strobes.
        if (legal) begin
          memAddress_o   = addr_q;
          memWriteData_o = write_q ? wdata_q : '0;
          memWrite_o     = write_q;
          memRead_o      = ~write_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    p0RspValid_d = (state_q == ACCESS) && !port_q;
    p1RspValid_d = (state_q == ACCESS) && port_q;
    p0RspData_d  = p0RspValid_d ? rspData : '0;
    p1RspData_d  = p1RspValid_d ? rspData : '0;
    p0RspErr_d   = p0RspValid_d && !legal;
    p1RspErr_d   = p1RspValid_d && !legal;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      port_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      port_q  <= port_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p0RspValid_q <= 1'b0;
      p0RspData_q  <= '0;
      p0RspErr_q   <= 1'b0;
      p1RspValid_q <= 1'b0;
      p1RspData_q  <= '0;
      p1RspErr_q   <= 1'b0;
    end else begin
      p0RspValid_q <= p0RspValid_d;
      p0RspData_q  <= p0RspData_d;
      p0RspErr_q   <= p0RspErr_d;
      p1RspValid_q <= p1RspValid_d;
      p1RspData_q  <= p1RspData_d;
      p1RspErr_q   <= p1RspErr_d;
    end
  end

  assign p0ReqReady_o = p0Ready;
  assign p1ReqReady_o = p1Ready;
  assign p0RspValid_o = p0RspValid_q;
  assign p0RspData_o  = p0RspData_q;
  assign p0RspErr_o   = p0RspErr_q;
  assign p1RspValid_o = p1RspValid_q;
  assign p1RspData_o  = p1RspData_q;
  assign p1RspErr_o   = p1RspErr_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed requests push expected grants/responses,
// a negedge monitor pops and compares them. Memory model starts as mem[i] = i.
module tb_data_mem_arbiter;

  typedef struct packed {
    logic [23:0] data;
    logic        err;
  } rsp_t;

  logic        clk;
  logic        rstN;
  logic [1:0]  reqValid;
  logic [1:0]  reqReady;
  logic [1:0]  reqWrite;
  logic [23:0] reqAddr0, reqAddr1, reqWData0, reqWData1;
  logic [1:0]  rspValid;
  logic [1:0]  rspErr;
  logic [23:0] rspData0, rspData1;
  logic [23:0] memAddress, memWriteData, memReadData;
  logic        memWrite, memRead;

  logic [7:0]  mem [128];
  bit          memLoaded = 1'b0;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int memWriteCycles = 0;
  int memReadCycles = 0;
  int ready1Cycles = 0;
  int hsCycle [2];
  bit b2bMode = 1'b0;
  rsp_t expQ0[$];
  rsp_t expQ1[$];
  int   expGrant[$];

  data_mem_arbiter dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .p0ReqValid_i   (reqValid[0]),
    .p0ReqReady_o   (reqReady[0]),
    .p0Write_i      (reqWrite[0]),
    .p0Addr_i       (reqAddr0),
    .p0WData_i      (reqWData0),
    .p0RspValid_o   (rspValid[0]),
    .p0RspData_o    (rspData0),
    .p0RspErr_o     (rspErr[0]),
    .p1ReqValid_i   (reqValid[1]),
    .p1ReqReady_o   (reqReady[1]),
    .p1Write_i      (reqWrite[1]),
    .p1Addr_i       (reqAddr1),
    .p1WData_i      (reqWData1),
    .p1RspValid_o   (rspValid[1]),
    .p1RspData_o    (rspData1),
    .p1RspErr_o     (rspErr[1]),
    .memAddress_o   (memAddress),
    .memWriteData_o (memWriteData),
    .memWrite_o     (memWrite),
    .memRead_o      (memRead),
    .memReadData_i  (memReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Big-endian byte memory: loads itself once, then commits writes on the rising edge.
  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i);
      memLoaded <= 1'b1;
    end else if (memWrite && memAddress <= 24'd125) begin
      mem[int'(memAddress)]     <= memWriteData[23:16];
      mem[int'(memAddress) + 1] <= memWriteData[15:8];
      mem[int'(memAddress) + 2] <= memWriteData[7:0];
    end
  end

  always_comb begin
    memReadData = '0;
    if (memAddress <= 24'd125)
      memReadData = {mem[int'(memAddress)], mem[int'(memAddress) + 1], mem[int'(memAddress) + 2]};
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  task automatic pushResp(input int p, input logic [23:0] data, input logic err);
    rsp_t r;
    r.data = data;
    r.err  = err;
    if (p == 0) expQ0.push_back(r);
    else        expQ1.push_back(r);
  endtask

  // Monitor: responses are checked before handshakes so back-to-back latency uses the older handshake.
  always @(negedge clk) begin
    if (rstN) begin
      if (memWrite) memWriteCycles++;
      if (memRead) memReadCycles++;
      if (reqReady[1]) ready1Cycles++;
      for (int p = 0; p < 2; p++) begin
        if (rspValid[p]) begin
          rsp_t e;
          logic [23:0] actData;
          bit have;
          have = 1'b0;
          e = '0;
          actData = (p == 0) ? rspData0 : rspData1;
          if (p == 0 && expQ0.size() > 0) begin e = expQ0.pop_front(); have = 1'b1; end
          if (p == 1 && expQ1.size() > 0) begin e = expQ1.pop_front(); have = 1'b1; end
          if (!have) checkOutput("unexpectedRsp", 32'(p), 32'd99);
          else begin
            checkOutput("rspData", 32'(actData), 32'(e.data));
            checkOutput("rspErr", 32'(rspErr[p]), 32'(e.err));
            checkOutput("rspLatency", 32'(cycle - hsCycle[p]), 32'd2);
          end
          if (p == 0) checkOutput("otherPortIdle", {7'd0, rspValid[1], rspData1}, 32'd0);
          else        checkOutput("otherPortIdle", {7'd0, rspValid[0], rspData0}, 32'd0);
          if (b2bMode && p == 0 && reqValid[0]) checkOutput("rspWithReady", 32'(reqReady[0]), 32'd1);
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (reqValid[p] && reqReady[p]) begin
          if (expGrant.size() == 0) checkOutput("unexpectedGrant", 32'(p), 32'd99);
          else                      checkOutput("grantPort", 32'(p), 32'(expGrant.pop_front()));
          hsCycle[p] = cycle;
        end
      end
    end
  end

  task automatic waitHandshake(input int p);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (reqValid[p] && reqReady[p]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("handshakeTimeout", 32'd0, 32'd1);
  endtask

  task automatic driveReq(input int p, input logic wr, input logic [23:0] addr, input logic [23:0] wd);
    reqValid[p] = 1'b1;
    reqWrite[p] = wr;
    if (p == 0) begin reqAddr0 = addr; reqWData0 = wd; end
    else        begin reqAddr1 = addr; reqWData1 = wd; end
  endtask

  // One complete request on a single port; valid drops just after the accepting edge.
  task automatic applyStimulus(input int p, input logic wr, input logic [23:0] addr, input logic [23:0] wd);
    @(posedge clk);
    #1;
    driveReq(p, wr, addr, wd);
    waitHandshake(p);
    @(posedge clk);
    #1;
    reqValid[p] = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_memStrobes"}, {30'd0, memWrite, memRead}, 32'd0);
    checkOutput({tag, "_memAddress"}, 32'(memAddress), 32'd0);
    checkOutput({tag, "_memWriteData"}, 32'(memWriteData), 32'd0);
    checkOutput({tag, "_rspValidErr"}, {28'd0, rspValid, rspErr}, 32'd0);
    checkOutput({tag, "_rspData0"}, 32'(rspData0), 32'd0);
    checkOutput({tag, "_rspData1"}, 32'(rspData1), 32'd0);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    reqValid = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkAllZero("reset");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wrBefore, rdBefore, rdyBefore, lastHs;
    rstN = 1'b0;
    reqValid = 2'b00;
    reqWrite = 2'b00;
    reqAddr0 = '0; reqAddr1 = '0; reqWData0 = '0; reqWData1 = '0;
    doReset();

    // Store then load on port 0; exactly one write strobe.
    wrBefore = memWriteCycles;
    expGrant.push_back(0); pushResp(0, 24'h000000, 1'b0);
    applyStimulus(0, 1'b1, 24'h000004, 24'hA1B2C3);
    checkOutput("storeWritePulse", 32'(memWriteCycles - wrBefore), 32'd1);
    expGrant.push_back(0); pushResp(0, 24'hA1B2C3, 1'b0);
    applyStimulus(0, 1'b0, 24'h000004, 24'h000000);

    // Both ports hold loads for 8 cycles starting from a fresh pointer.
    doReset();
    rdyBefore = ready1Cycles;
`ifdef ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 2; i++) begin
      expGrant.push_back(0); pushResp(0, 24'hA1B2C3, 1'b0);
      expGrant.push_back(1); pushResp(1, 24'h101112, 1'b0);
    end
`else
    for (int i = 0; i < 4; i++) begin
      expGrant.push_back(0); pushResp(0, 24'hA1B2C3, 1'b0);
    end
`endif
    @(posedge clk);
    #1;
    driveReq(0, 1'b0, 24'h000004, 24'h0);
    driveReq(1, 1'b0, 24'h000010, 24'h0);
    repeat (8) @(posedge clk);
    #1;
    reqValid = 2'b00;
    repeat (3) @(posedge clk);
`ifndef ARB_ROUND_ROBIN_EN
    checkOutput("p1NeverReady", 32'(ready1Cycles - rdyBefore), 32'd0);
`endif

    // Out-of-range accesses on port 1 must never touch memory.
    wrBefore = memWriteCycles;
    rdBefore = memReadCycles;
    expGrant.push_back(1); pushResp(1, 24'h000000, 1'b1);
    applyStimulus(1, 1'b0, 24'h00007E, 24'h0);
    expGrant.push_back(1); pushResp(1, 24'h000000, 1'b1);
    applyStimulus(1, 1'b1, 24'hFFFFFF, 24'h123456);
    checkOutput("illegalNoStrobe", 32'((memWriteCycles - wrBefore) + (memReadCycles - rdBefore)), 32'd0);
    checkOutput("memTailUnchanged", {8'd0, mem[125], mem[126], mem[127]}, 32'h007D7E7F);
    expGrant.push_back(1); pushResp(1, 24'h7D7E7F, 1'b0);
    applyStimulus(1, 1'b0, 24'h00007D, 24'h0);

    // Reset in the middle of a store's access cycle.
    expGrant.push_back(0);
    @(posedge clk);
    #1;
    driveReq(0, 1'b1, 24'h000020, 24'h112233);
    waitHandshake(0);
    @(posedge clk);
    #2;
    checkOutput("memWriteInAccess", 32'(memWrite), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("memWriteDropOnReset", 32'(memWrite), 32'd0);
    reqValid = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkAllZero("midReset");
    expGrant.push_back(0); pushResp(0, 24'h7D7E7F, 1'b0);
    @(posedge clk);
    #1;
    driveReq(0, 1'b0, 24'h00007D, 24'h0);
    driveReq(1, 1'b0, 24'h000010, 24'h0);
    waitHandshake(0);
    @(posedge clk);
    #1;
    reqValid = 2'b00;
    repeat (2) @(posedge clk);

    // Back-to-back port 0 loads with valid held high.
    b2bMode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expGrant.push_back(0); pushResp(0, 24'h000102, 1'b0);
    end
    @(posedge clk);
    #1;
    driveReq(0, 1'b0, 24'h000000, 24'h0);
    lastHs = 0;
    for (int i = 0; i < 3; i++) begin
      waitHandshake(0);
      if (i > 0) checkOutput("handshakeSpacing", 32'(cycle - lastHs), 32'd2);
      lastHs = cycle;
    end
    @(posedge clk);
    #1;
    reqValid = 2'b00;
    repeat (3) @(posedge clk);
    b2bMode = 1'b0;

    checkOutput("scoreboardDrained", 32'(expQ0.size() + expQ1.size() + expGrant.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer in front of the 24-bit, byte-addressed, big-endian data memory (128 bytes, 3 bytes per word). It shares the memory between requester port 0 (CPU load/store stage) and requester port 1 (DMA/debug loader). It accepts one request per grant through a valid/ready handshake, drives the memory control signals for exactly one access cycle and returns a registered response to the winning port. It also rejects accesses whose 3-byte word would run past the end of memory.

## Interface
- MEM_BYTES, 128: memory size in bytes; legal word address range is 0..MEM_BYTES-3.
- ADDR_W, 24: address width.
- DATA_W, 24: word width.
- Clock  in  1  single clock; all state updates on rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- P0ReqValid / P1ReqValid  in  1  request present.
- P0ReqReady / P1ReqReady  out  1  request accepted this cycle (combinational).
- P0Write / P1Write  in  1  1 = store, 0 = load.
- P0Addr / P1Addr  in  ADDR_W  byte address of the most significant byte.
- P0WData / P1WData  in  DATA_W  store data.
- P0RspValid / P1RspValid  out  1  one-cycle response strobe.
- P0RspData / P1RspData  out  DATA_W  load data; 0 for stores and errors.
- P0RspErr / P1RspErr  out  1  address out of range; valid with RspValid.
- MemAddress  out  ADDR_W  to memory Address.
- MemWriteData  out  DATA_W  to memory WriteData.
- MemWrite  out  1  to memory MemWrite.
- MemRead  out  1  to memory MemRead.
- MemReadData  in  DATA_W  combinational read data from memory.

## Operation
- State machine states:
  - IDLE: at most one ReqReady high, for the arbitration winner. A handshake (Valid && Ready) latches Write, Addr, WData and the port id, then moves to ACCESS. With no request, stay in IDLE.
  - ACCESS: lasts exactly one cycle, then returns to IDLE.
    - Legal address (Addr <= MEM_BYTES-3): MemAddress = latched Addr. Store asserts MemWrite with MemWriteData = latched WData; load asserts MemRead.
    - Illegal address: MemWrite and MemRead stay 0.
    - At the closing edge, the granted port's RspValid, RspData and RspErr are registered.
- Outside ACCESS: MemWrite = MemRead = 0, MemAddress = 0, MemWriteData = 0.
- RspData is MemReadData for a legal load and 0 otherwise. RspErr = 1 only for an illegal address.
- Address compare uses the full ADDR_W bits. There is no wrap-around: an address of 0xFFFFFF is illegal.
- RspValid is high for exactly one cycle and only on the port that was granted. The other port's response outputs hold 0.
- A port may hold ReqValid through its own response. Once it returns to IDLE it competes again.

## Timing
- Reset (asynchronous assert, synchronous release): state = IDLE, all Rsp* outputs = 0, all Mem* outputs = 0, round-robin pointer = port 1 (so port 0 wins first).
- Reset asserted during ACCESS drops MemWrite immediately. That write is not guaranteed to commit and no response is produced.
- Latency: handshake at edge k, memory access during cycle k..k+1, RspValid high in cycle k+1.
- Throughput: one access per 2 cycles. A new handshake is allowed in the same cycle RspValid is high.
- ReqReady depends combinationally on ReqValid and state only, never on ReqReady.
- Simultaneous requests resolve in a single cycle. The loser keeps ReqValid and is not accepted.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
  - On a simultaneous request, the port not granted last wins.
  - The pointer updates on every handshake.
  - Neither port can be starved for more than one access.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins a simultaneous request. There is no pointer register and port 1 may starve.

## Test plan
- Port 0 store Addr=0x000004, WData=0xA1B2C3, then load Addr=0x000004 -> MemWrite high for exactly one cycle; load RspData=0xA1B2C3, RspErr=0, RspValid in the cycle after each handshake.
- Port 0 and port 1 both hold ReqValid (loads) for 8 cycles:
  - With ARB_ROUND_ROBIN_EN: grants alternate P0,P1,P0,P1.
  - Without it: only P0 is granted and P1ReqReady stays 0.
- Port 1 load Addr=0x00007E, and store Addr=0xFFFFFF -> RspErr=1, RspData=0, MemWrite and MemRead never asserted; memory contents unchanged.
- Port 1 load Addr=0x00007D (last legal word) -> RspErr=0; RspData = bytes 0x7D,0x7E,0x7F concatenated big-endian.
- Assert ResetN low mid-ACCESS of a store -> MemWrite falls in the same cycle, no RspValid; after release, all outputs are 0 and the next simultaneous request grants port 0.
- Back-to-back port 0 requests with continuous ReqValid -> handshakes every 2 cycles; RspValid coincides with the next ReqReady.
